// File: rtl/synth_pkg.sv
// Shared widths, FSM state type and octave select type for the wavetable voice.
package synth_pkg;

   localparam int unsigned SAMP_W  = 16;
   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned PHASE_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      INTERP,
      MIX
   } voice_state_t;

   typedef logic [7:0] octave_oh_t;

endpackage

// File: rtl/wavetable_voice_ctrl_if.sv
// Voice controller <-> square wavetable ROM link: address/enable/octave out,
// adjacent-sample pairs for the two octave banks back.
interface wavetable_voice_ctrl_if;
   import synth_pkg::*;

   logic [ADDR_W-1:0]        sampAddrA;
   logic                     readEn;
   octave_oh_t               octave;
   // [0] = selected octave bank, [1] = octave>>1 bank
   logic signed [SAMP_W-1:0] interpOuts     [2];
   logic signed [SAMP_W-1:0] antiInterpOuts [2];

   // Controller side
   modport master (
      output sampAddrA, readEn, octave,
      input  interpOuts, antiInterpOuts
   );

   // ROM side
   modport slave (
      input  sampAddrA, readEn, octave,
      output interpOuts, antiInterpOuts
   );

endinterface

// File: rtl/lerp_s16.sv
// Signed 16-bit linear blend: y = a + (((b - a) * w) >>> W), floor rounding.
// The result always lies between a and b, so it fits SAMP_W without saturation.
module lerp_s16
   import synth_pkg::*;
#(
   parameter int unsigned W = 12
) (
   input  logic signed [SAMP_W-1:0] a,
   input  logic signed [SAMP_W-1:0] b,
   input  logic        [W-1:0]      w,
   output logic signed [SAMP_W-1:0] y
);

   localparam int unsigned PW = SAMP_W + W + 2;

   logic signed [SAMP_W:0] diff;
   logic signed [PW-1:0]   prod;
   logic signed [PW-1:0]   step;
   logic signed [PW-1:0]   sum;

   // Full-precision difference and weighted step; weight is treated as unsigned.
   always_comb begin
      diff = (SAMP_W + 1)'(b) - (SAMP_W + 1)'(a);
      prod = PW'(diff) * PW'($signed({1'b0, w}));
      step = prod >>> W;
      sum  = step + PW'(a);
      y    = SAMP_W'(sum);
   end

endmodule

// File: rtl/wavetable_voice_ctrl.sv
// Per-voice oscillator controller: runs the phase accumulator, sequences one ROM
// read per sample tick, interpolates both octave banks and crossfades them.
module wavetable_voice_ctrl
   import synth_pkg::*;
#(
   parameter int unsigned ROM_LAT = 2,
   parameter int unsigned FRAC_W  = 12
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     sample_tick,
   input  logic [PHASE_W-1:0]       phase_inc,
   input  logic                     phase_rst,
   input  octave_oh_t               octave_in,
   input  logic [7:0]               xfade,
   wavetable_voice_ctrl_if.master   rom,
   output logic signed [SAMP_W-1:0] sample_out,
   output logic                     sample_valid,
   output logic                     busy,
   output logic                     overrun
);

   localparam int unsigned CNT_W     = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam int unsigned LAST_WAIT = (ROM_LAT > 1) ? ROM_LAT - 2 : 0;

   voice_state_t             stateQ, stateD;
   logic [CNT_W-1:0]         waitCntQ, waitCntD;
   logic                     accept;

   logic [PHASE_W-1:0]       phaseQ;
   logic                     rstPendQ;

   logic [ADDR_W-1:0]        addrQ;
   logic [FRAC_W-1:0]        fracQ;
   octave_oh_t               octaveQ;
   logic [7:0]               xfadeQ;

   logic signed [SAMP_W-1:0] y0, y1, y0Q, y1Q;
   logic signed [SAMP_W-1:0] mixed;
   logic signed [SAMP_W-1:0] sampleQ;
   logic                     validQ;
   logic                     overrunQ;

   // State register and WAIT-phase cycle counter.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         stateQ   <= IDLE;
         waitCntQ <= '0;
      end else begin
         stateQ   <= stateD;
         waitCntQ <= waitCntD;
      end
   end

   // Next-state sequencing and state-decoded outputs.
   always_comb begin
      stateD     = stateQ;
      waitCntD   = waitCntQ;
      accept     = 1'b0;
      busy       = (stateQ != IDLE);
      rom.readEn = 1'b0;
      unique case (stateQ)
         IDLE: begin
            if (sample_tick) begin
               accept = 1'b1;
               stateD = READ;
            end
         end
         READ: begin
            rom.readEn = 1'b1;
            waitCntD   = '0;
            stateD     = (ROM_LAT > 1) ? WAIT : INTERP;
         end
         WAIT: begin
            if (waitCntQ == CNT_W'(LAST_WAIT)) begin
               stateD = INTERP;
            end else begin
               waitCntD = waitCntQ + CNT_W'(1);
            end
         end
         INTERP:  stateD = MIX;
         MIX:     stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // Phase accumulator; a phase_rst seen mid-sequence is parked until MIX so the
   // in-flight read keeps the phase it started with.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         phaseQ   <= '0;
         rstPendQ <= 1'b0;
      end else if (stateQ == IDLE) begin
         rstPendQ <= 1'b0;
         if (phase_rst) begin
            phaseQ <= '0;
         end
      end else if (stateQ == MIX) begin
         rstPendQ <= 1'b0;
         phaseQ   <= (rstPendQ || phase_rst) ? '0 : phaseQ + phase_inc;
      end else if (phase_rst) begin
         rstPendQ <= 1'b1;
      end
   end

   // Per-sequence operands, captured as the tick is accepted and held until IDLE.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         addrQ   <= '0;
         fracQ   <= '0;
         octaveQ <= '0;
         xfadeQ  <= '0;
      end else if (accept) begin
         // A note-on arriving with the tick reads from phase zero.
         addrQ   <= phase_rst ? '0 : phaseQ[PHASE_W-1 -: ADDR_W];
         fracQ   <= phase_rst ? '0 : phaseQ[PHASE_W-ADDR_W-1 -: FRAC_W];
         octaveQ <= octave_in;
         xfadeQ  <= xfade;
      end
   end

   assign rom.sampAddrA = addrQ;
   assign rom.octave    = octaveQ;

   lerp_s16 #(
      .W (FRAC_W)
   ) lerpBank0 (
      .a (rom.interpOuts[0]),
      .b (rom.antiInterpOuts[0]),
      .w (fracQ),
      .y (y0)
   );

   lerp_s16 #(
      .W (FRAC_W)
   ) lerpBank1 (
      .a (rom.interpOuts[1]),
      .b (rom.antiInterpOuts[1]),
      .w (fracQ),
      .y (y1)
   );

   lerp_s16 #(
      .W (8)
   ) lerpMix (
      .a (y0Q),
      .b (y1Q),
      .w (xfadeQ),
      .y (mixed)
   );

   // Bank results taken at end of INTERP, mixed sample committed at end of MIX.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         y0Q      <= '0;
         y1Q      <= '0;
         sampleQ  <= '0;
         validQ   <= 1'b0;
         overrunQ <= 1'b0;
      end else begin
         if (stateQ == INTERP) begin
            y0Q <= y0;
            y1Q <= y1;
         end
         if (stateQ == MIX) begin
            sampleQ <= mixed;
         end
         validQ   <= (stateQ == MIX);
         overrunQ <= sample_tick && busy;
      end
   end

   assign sample_out   = sampleQ;
   assign sample_valid = validQ;
   assign overrun      = overrunQ;

endmodule

// File: tb/tb_wavetable_voice_ctrl.sv
// Scoreboard bench for wavetable_voice_ctrl: a latency-accurate ROM model, a
// spec-level reference model feeding expectation queues, and a monitor.
module tb_wavetable_voice_ctrl;
   import synth_pkg::*;

   localparam int unsigned ROM_LAT = 2;
   localparam int unsigned FRAC_W  = 12;
   localparam int          SEQ_LEN = ROM_LAT + 2;  // accepting edge -> MIX edge

   logic              Clk = 1'b0;
   logic              Reset_n = 1'b0;
   logic              sample_tick = 1'b0;
   logic [31:0]       phase_inc = '0;
   logic              phase_rst = 1'b0;
   octave_oh_t        octave_in = '0;
   logic [7:0]        xfade = '0;
   logic signed [15:0] sample_out;
   logic              sample_valid;
   logic              busy;
   logic              overrun;

   wavetable_voice_ctrl_if romIf ();

   wavetable_voice_ctrl #(
      .ROM_LAT (ROM_LAT),
      .FRAC_W  (FRAC_W)
   ) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .sample_tick  (sample_tick),
      .phase_inc    (phase_inc),
      .phase_rst    (phase_rst),
      .octave_in    (octave_in),
      .xfade        (xfade),
      .rom          (romIf),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 Clk = ~Clk;

   int edgeCnt = 0;
   always @(posedge Clk) edgeCnt <= edgeCnt + 1;

   // ROM model: data for the captured address appears ROM_LAT cycles after readEn,
   // random junk otherwise.
   logic signed [15:0] rom [2][4096];
   logic               vp [ROM_LAT];
   logic [11:0]        ap [ROM_LAT];
   logic signed [15:0] junk [2];

   always @(posedge Clk) begin
      vp[0] <= romIf.readEn;
      ap[0] <= romIf.sampAddrA;
      for (int i = 1; i < ROM_LAT; i++) begin
         vp[i] <= vp[i-1];
         ap[i] <= ap[i-1];
      end
      junk[0] <= 16'($urandom);
      junk[1] <= 16'($urandom);
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         romIf.interpOuts[k]     = vp[ROM_LAT-1] ? rom[k][ap[ROM_LAT-1]] : junk[k];
         romIf.antiInterpOuts[k] = vp[ROM_LAT-1] ? rom[k][ap[ROM_LAT-1] + 12'd1] : ~junk[k];
      end
   end

   int nChecks = 0;
   int nErrors = 0;

   task automatic check(input string name, input longint got, input longint exp);
      nChecks++;
      if (got != exp) begin
         nErrors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   typedef struct { int edgeN; int addr; int oct; } readExp_t;
   typedef struct { int edgeN; int value; } sampExp_t;

   readExp_t readQ [$];
   sampExp_t sampQ [$];
   int       ovQ   [$];

   int lastAddr = 0;
   int lastSample = 0;
   int nValid = 0;
   int ovCount = 0;

   // Reference model state
   bit [31:0] mPhase = '0;
   bit        mPend = 1'b0;
   int        accEdge = -100;

   // Expected result of a sequence reading the model's current phase.
   task automatic expectSeq(input int n, input octave_oh_t oct, input logic [7:0] xf);
      int addr, frac, a, b, z;
      int y [2];
      addr = int'(mPhase[31:20]);
      frac = int'(mPhase[19:0] >> (20 - FRAC_W));
      for (int k = 0; k < 2; k++) begin
         a = int'(rom[k][addr]);
         b = int'(rom[k][(addr + 1) % 4096]);
         y[k] = a + (((b - a) * frac) >>> FRAC_W);
      end
      z = y[0] + (((y[1] - y[0]) * int'(xf)) >>> 8);
      readQ.push_back('{n, addr, int'(oct)});
      sampQ.push_back('{n + SEQ_LEN, z});
   endtask

   // Drive one cycle of inputs, advance the model for the edge that samples them.
   task automatic doCycle(input bit tick, input bit prst, input logic [31:0] inc,
                          input octave_oh_t oct, input logic [7:0] xf);
      int n;
      bit mBusy;
      n = edgeCnt + 1;
      sample_tick = tick;
      phase_rst   = prst;
      phase_inc   = inc;
      octave_in   = oct;
      xfade       = xf;
      mBusy = (n > accEdge) && (n <= accEdge + SEQ_LEN);
      if (mBusy) begin
         if (prst) mPend = 1'b1;
         if (n == accEdge + SEQ_LEN) begin
            mPhase = mPend ? 32'd0 : mPhase + inc;
            mPend  = 1'b0;
         end
         if (tick) ovQ.push_back(n);
      end else begin
         if (prst) mPhase = '0;
         if (tick) begin
            expectSeq(n, oct, xf);
            accEdge = n;
         end
      end
      @(posedge Clk);
      #1;
      sample_tick = 1'b0;
      phase_rst   = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) doCycle(1'b0, 1'b0, phase_inc, octave_in, xfade);
   endtask

   task automatic seq(input bit prst, input logic [31:0] inc, input logic [7:0] xf);
      doCycle(1'b1, prst, inc, 8'h01, xf);
      idle(SEQ_LEN + 2);
   endtask

   // Monitor: pop and compare whenever the DUT presents a read, sample or overrun.
   always @(negedge Clk) begin : monitor
      readExp_t re;
      sampExp_t se;
      int       oe;
      if (Reset_n) begin
         if (romIf.readEn) begin
            if (readQ.size() == 0) begin
               check("readEn without expectation", romIf.readEn, 0);
            end else begin
               re = readQ.pop_front();
               check("readEn cycle", edgeCnt, re.edgeN);
               check("sampAddrA", romIf.sampAddrA, re.addr);
               check("octave", romIf.octave, re.oct);
            end
            lastAddr = int'(romIf.sampAddrA);
         end
         if (sample_valid) begin
            if (sampQ.size() == 0) begin
               check("sample_valid without expectation", sample_valid, 0);
            end else begin
               se = sampQ.pop_front();
               check("sample_valid cycle", edgeCnt, se.edgeN);
               check("sample_out", sample_out, se.value);
            end
            lastSample = int'(sample_out);
            nValid++;
         end
         if (overrun) begin
            if (ovQ.size() == 0) begin
               check("overrun without expectation", overrun, 0);
            end else begin
               oe = ovQ.pop_front();
               check("overrun cycle", edgeCnt, oe);
            end
            ovCount++;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int v0, o0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4096; i++) rom[k][i] = 16'($urandom);
      end

      // Reset state
      repeat (3) @(posedge Clk);
      #1;
      check("reset sampAddrA", romIf.sampAddrA, 0);
      check("reset readEn", romIf.readEn, 0);
      check("reset octave", romIf.octave, 0);
      check("reset sample_out", sample_out, 0);
      check("reset sample_valid", sample_valid, 0);
      check("reset busy", busy, 0);
      check("reset overrun", overrun, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
      idle(6);
      check("idle busy", busy, 0);

      // Address stepping, one ROM entry per tick
      doCycle(1'b1, 1'b1, 32'h0010_0000, 8'h04, 8'h40);
      idle(7);
      for (int t = 0; t < 4; t++) begin
         doCycle(1'b1, 1'b0, 32'h0010_0000, 8'h01 << t, 8'(t * 60));
         idle(7);
      end
      check("stepped address", lastAddr, 4);

      // Interpolation
      rom[0][5] = 16'sd1000;
      rom[0][6] = 16'sd2000;
      seq(1'b1, 32'h0058_0000, 8'd0);
      seq(1'b0, 32'h0000_0000, 8'd0);
      check("interp midpoint", lastSample, 1500);
      rom[0][7] = -16'sd2000;
      rom[0][8] = 16'sd1000;
      seq(1'b1, 32'h0074_0000, 8'd0);
      seq(1'b0, 32'h0000_0000, 8'd0);
      check("interp quarter", lastSample, -1250);

      // Crossfade
      rom[0][9] = 16'sh1000;
      rom[1][9] = -16'sh1000;
      seq(1'b1, 32'h0090_0000, 8'd0);
      seq(1'b0, 32'h0000_0000, 8'd128);
      check("xfade 128", lastSample, 0);
      seq(1'b0, 32'h0000_0000, 8'd0);
      check("xfade 0", lastSample, 'h1000);
      seq(1'b0, 32'h0000_0000, 8'd255);
      check("xfade 255", lastSample, -'h0FE0);

      // Wrap and phase reset
      seq(1'b1, 32'hFFF0_0000, 8'd77);
      seq(1'b0, 32'h0010_0000, 8'd77);
      check("wrap addr 4095", lastAddr, 4095);
      seq(1'b0, 32'h0010_0000, 8'd77);
      check("wrap addr 0", lastAddr, 0);
      seq(1'b0, 32'h1234_5678, 8'd9);
      seq(1'b1, 32'h0300_0000, 8'd9);
      check("phase_rst with tick addr", lastAddr, 0);
      doCycle(1'b1, 1'b0, 32'h0050_0000, 8'h02, 8'd3);
      doCycle(1'b0, 1'b1, 32'h0050_0000, 8'h02, 8'd3);
      idle(SEQ_LEN + 2);
      seq(1'b0, 32'h0010_0000, 8'd3);
      check("phase_rst while busy addr", lastAddr, 0);

      // Overrun: second tick two cycles later is dropped
      v0 = nValid;
      o0 = ovCount;
      doCycle(1'b1, 1'b0, 32'h0020_0000, 8'h08, 8'd200);
      doCycle(1'b0, 1'b0, 32'h0020_0000, 8'h08, 8'd200);
      doCycle(1'b1, 1'b0, 32'h0020_0000, 8'h10, 8'd10);
      idle(8);
      check("samples for overrun pair", nValid - v0, 1);
      check("overrun pulses", ovCount - o0, 1);

      // Asynchronous reset during WAIT aborts the sequence
      v0 = nValid;
      doCycle(1'b1, 1'b0, 32'h0020_0000, 8'h20, 8'd50);
      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check("abort readEn", romIf.readEn, 0);
      check("abort busy", busy, 0);
      check("abort sample_valid", sample_valid, 0);
      check("abort sampAddrA", romIf.sampAddrA, 0);
      sampQ.delete();
      readQ.delete();
      ovQ.delete();
      mPhase = '0;
      mPend = 1'b0;
      accEdge = -100;
      repeat (2) @(posedge Clk);
      #3;
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
      check("no sample from aborted sequence", nValid - v0, 0);
      seq(1'b0, 32'h0040_0000, 8'd50);
      check("post-abort addr", lastAddr, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         doCycle(($urandom % 3) == 0, ($urandom % 16) == 0, $urandom,
                 8'(1 << $urandom_range(7, 0)), 8'($urandom));
      end
      idle(10);

      check("read queue drained", readQ.size(), 0);
      check("sample queue drained", sampQ.size(), 0);
      check("overrun queue drained", ovQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
